// File: rtl/simple_fixed_point_signed_long_division.sv
// Free-running signed fixed-point divider: samples data_in, divides it by the
// compile-time DIVISOR with bit-serial restoring long division (one quotient
// bit per clock), truncates toward zero, saturates and holds the result on
// data_out until the next result is ready.
//
// Schedule: LOAD (1 cycle) -> DIV (WIDTH+FRAC_BITS cycles) -> DONE (1 cycle).
// data_out updates on the (1+WIDTH+FRAC_BITS)-th rising edge after the edge
// that sampled data_in; data_in is ignored outside LOAD. There is no
// handshake: consumers may read data_out at any time and always see the most
// recently completed result.
module simple_fixed_point_signed_long_division #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 4,
  parameter int DIVISOR   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam int QW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  // Divisor as a WIDTH-bit two's-complement pattern; magnitude kept in WIDTH+1
  // bits so that |-2^(WIDTH-1)| is exact.
  localparam logic [WIDTH-1:0] DIV_BITS = DIVISOR[WIDTH-1:0];
  localparam logic             DIV_SIGN = DIV_BITS[WIDTH-1];
  localparam logic [WIDTH:0]   DIV_SX   = {DIV_BITS[WIDTH-1], DIV_BITS};
  localparam logic [WIDTH:0]   DIV_MAG  = DIV_SX[WIDTH] ? -DIV_SX : DIV_SX;

  localparam logic signed [QW:0] SAT_MAX = (QW+1)'(2**(WIDTH-1) - 1);
  localparam logic signed [QW:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {LOAD, DIV, DONE} state_t;

  state_t          state;
  logic            sign;
  logic [QW-1:0]   dividend;
  logic [WIDTH:0]  rem;
  logic [QW-1:0]   quot;
  logic [CW-1:0]   cnt;

  logic [WIDTH:0]      din_ext;
  logic [WIDTH:0]      din_abs;
  logic [QW-1:0]       mag_load;
  logic [WIDTH:0]      trial;
  logic                ge;
  logic [WIDTH:0]      rem_next;
  logic [QW:0]         quot_ext;
  logic signed [QW:0]  signed_q;
  logic [WIDTH-1:0]    sat_q;

  // Datapath: input magnitude, one restoring-division step, sign and saturation.
  always_comb begin
    din_ext  = {data_in[WIDTH-1], data_in};
    din_abs  = din_ext[WIDTH] ? -din_ext : din_ext;
    mag_load = {{(QW-WIDTH-1){1'b0}}, din_abs} << FRAC_BITS;

    // A bit shifted out of the remainder means the shifted value already
    // exceeds any representable divisor magnitude.
    trial    = {rem[WIDTH-1:0], dividend[QW-1]};
    ge       = rem[WIDTH] | (trial >= DIV_MAG);
    rem_next = ge ? (trial - DIV_MAG) : trial;

    quot_ext = {1'b0, quot};
    signed_q = sign ? -$signed(quot_ext) : $signed(quot_ext);

    if (signed_q > SAT_MAX)
      sat_q = {1'b0, {(WIDTH-1){1'b1}}};
    else if (signed_q < SAT_MIN)
      sat_q = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sat_q = signed_q[WIDTH-1:0];
  end

  // Control FSM and all state registers, including the held output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      data_out <= '0;
      sign     <= 1'b0;
      dividend <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        LOAD: begin
          sign     <= data_in[WIDTH-1] ^ DIV_SIGN;
          dividend <= mag_load;
          rem      <= '0;
          quot     <= '0;
          cnt      <= '0;
          state    <= DIV;
        end
        DIV: begin
          dividend <= {dividend[QW-2:0], 1'b0};
          rem      <= rem_next;
          quot     <= {quot[QW-2:0], ge};
          if (cnt == CNT_LAST)
            state <= DONE;
          else
            cnt <= cnt + CW'(1);
        end
        DONE: begin
          data_out <= sat_q;
          state    <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_fixed_point_signed_long_division.sv
// Bench for simple_fixed_point_signed_long_division. Four instances share
// clk/reset/data_in and differ only in DIVISOR (2.0, 1/16, -2.0, 0), so each
// vector checks all four divisor configurations at once.
module tb_simple_fixed_point_signed_long_division;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic [7:0] dout_p32;
  logic [7:0] dout_p1;
  logic [7:0] dout_m32;
  logic [7:0] dout_z;

  int errors = 0;
  int checks = 0;

  logic [7:0] prev_p32, prev_p1, prev_m32, prev_z;

  typedef struct {
    logic [7:0] din;
    logic [7:0] e_p32;
    logic [7:0] e_p1;
    logic [7:0] e_m32;
    logic [7:0] e_z;
  } vec_t;

  vec_t vecs [10];

  simple_fixed_point_signed_long_division #(.WIDTH(8), .FRAC_BITS(4), .DIVISOR(32)) u_p32 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_p32));
  simple_fixed_point_signed_long_division #(.WIDTH(8), .FRAC_BITS(4), .DIVISOR(1)) u_p1 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_p1));
  simple_fixed_point_signed_long_division #(.WIDTH(8), .FRAC_BITS(4), .DIVISOR(-32)) u_m32 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_m32));
  simple_fixed_point_signed_long_division #(.WIDTH(8), .FRAC_BITS(4), .DIVISOR(0)) u_z (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_z));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_p32, input logic [7:0] e_p1,
                           input logic [7:0] e_m32, input logic [7:0] e_z);
    check({tag, " div=+32"}, dout_p32, e_p32);
    check({tag, " div=+1"},  dout_p1,  e_p1);
    check({tag, " div=-32"}, dout_m32, e_m32);
    check({tag, " div=0"},   dout_z,   e_z);
  endtask

  // Call when the next rising edge is a LOAD edge. Scrambles data_in during
  // DIV, checks the old result is still held at edge 12 and the new one
  // appears at edge 13. Returns with the next edge again a LOAD edge.
  task automatic run_sample(input string tag, input logic [7:0] din,
                            input logic [7:0] e_p32, input logic [7:0] e_p1,
                            input logic [7:0] e_m32, input logic [7:0] e_z);
    data_in = din;
    @(posedge clk); #1;
    for (int i = 1; i <= 11; i++) begin
      data_in = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check_all({tag, " hold@12"}, prev_p32, prev_p1, prev_m32, prev_z);
    @(posedge clk); #1;
    check_all({tag, " result@13"}, e_p32, e_p1, e_m32, e_z);
    prev_p32 = e_p32;
    prev_p1  = e_p1;
    prev_m32 = e_m32;
    prev_z   = e_z;
  endtask

  initial begin
    //            din    /+2.0  /(1/16) /-2.0  /0
    vecs[0] = '{8'h40, 8'h20, 8'h7F, 8'hE0, 8'h7F};
    vecs[1] = '{8'hC0, 8'hE0, 8'h80, 8'h20, 8'h80};
    vecs[2] = '{8'h80, 8'hC0, 8'h80, 8'h40, 8'h80};
    vecs[3] = '{8'h7F, 8'h3F, 8'h7F, 8'hC1, 8'h7F};
    vecs[4] = '{8'h03, 8'h01, 8'h30, 8'hFF, 8'h7F};
    vecs[5] = '{8'hFD, 8'hFF, 8'hD0, 8'h01, 8'h80};
    vecs[6] = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h7F};
    vecs[7] = '{8'hFF, 8'h00, 8'hF0, 8'h00, 8'h80};
    vecs[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h7F};
    vecs[9] = '{8'hFF, 8'h00, 8'hF0, 8'h00, 8'h80};

    prev_p32 = 8'h00;
    prev_p1  = 8'h00;
    prev_m32 = 8'h00;
    prev_z   = 8'h00;

    // Reset for 3 cycles with a non-zero input present
    reset   = 1'b1;
    data_in = 8'h40;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;

    // Table: back-to-back samples, 14-cycle period
    for (int v = 0; v < 10; v++)
      run_sample($sformatf("vec%0d din=%02h", v, vecs[v].din), vecs[v].din,
                 vecs[v].e_p32, vecs[v].e_p1, vecs[v].e_m32, vecs[v].e_z);

    // Reset in the middle of DIV aborts the division and clears data_out
    data_in = 8'h40;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all("mid-div reset", 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    check_all("reset held", 8'h00, 8'h00, 8'h00, 8'h00);
    reset    = 1'b0;
    prev_p32 = 8'h00;
    prev_p1  = 8'h00;
    prev_m32 = 8'h00;
    prev_z   = 8'h00;

    // First result after reset, then a repeat to confirm the period
    run_sample("post-reset C0", 8'hC0, 8'hE0, 8'h80, 8'h20, 8'h80);
    run_sample("post-reset 03", 8'h03, 8'h01, 8'h30, 8'hFF, 8'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
